sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter OST_DEPTH, default 4, SHALL set the maximum number of outstanding transactions (a power of 2, 2..16).
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 inst_req/inst_wr  input  1 each  instruction-side request and write flag.
REQ-005 inst_size  input  2; inst_wstrb  input  4; inst_addr  input  32; inst_wdata  input  32.
REQ-006 inst_addr_ok/inst_data_ok  output  1 each; inst_rdata  output  32.
REQ-007 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata SHALL have the same directions and widths as the inst_* ports, for the data side.
REQ-008 mem_req, mem_wr (output 1 each), mem_size (output 2), mem_wstrb (output 4), mem_addr, mem_wdata (output 32) form the shared slave-side request.
REQ-009 mem_addr_ok, mem_data_ok (input 1 each) and mem_rdata (input 32) form the slave-side response.
REQ-010 err_stray  output  1  sticky flag: mem_data_ok seen with no transaction outstanding.

Function
REQ-011 The arbiter FSM SHALL have two states: IDLE (no pending address phase) and LOCK (an address phase has been presented but not accepted).
REQ-012 In IDLE, when both requests are high, the winner SHALL be chosen by the policy in REQ-026; when one request is high, that side SHALL win.
REQ-013 In LOCK, the grant SHALL stay fixed on the locked side until mem_addr_ok, whatever the other request does.
REQ-014 mem_req SHALL equal (winner request) & ~ost_full; all mem_* request fields SHALL mux from the granted side combinationally.
REQ-015 IDLE->LOCK SHALL occur when mem_req=1 & mem_addr_ok=0; LOCK->IDLE SHALL occur when mem_addr_ok=1.
REQ-016 x_addr_ok SHALL be asserted only for the granted side, and only when mem_req & mem_addr_ok; it SHALL be combinational, with zero latency.
REQ-017 Each accepted address handshake SHALL push the owner ID (0=inst, 1=data) into an OST_DEPTH-entry owner FIFO.
REQ-018 mem_data_ok SHALL route to x_data_ok of the FIFO-head owner; the FIFO SHALL pop in the same cycle.
REQ-019 mem_rdata SHALL drive both inst_rdata and data_rdata unchanged; only data_ok qualifies them.
REQ-020 When the FIFO is full, mem_req SHALL be 0 even if a pop occurs in the same cycle; the request is reissued the next cycle.
REQ-021 A simultaneous push and pop SHALL leave the count unchanged, with both pointers advancing and wrapping modulo OST_DEPTH.
REQ-022 mem_data_ok while the FIFO is empty SHALL assert no x_data_ok, SHALL leave the FIFO unchanged, and SHALL set err_stray.
REQ-023 The arbiter SHALL add no cycles: the address handshake is combinational and responses are forwarded in order, with zero added latency.

Reset
REQ-024 On rst=1 the FSM SHALL go to IDLE, the FIFO SHALL empty (pointers and count 0), err_stray SHALL be 0, and the RR pointer SHALL favor data; this SHALL take effect immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-transaction SHALL discard all outstanding IDs; any later mem_data_ok for them SHALL set err_stray.

Configuration
REQ-026 With macro SRAM_ARB_RR_EN defined, ties SHALL be resolved round-robin: the pointer flips to the other side after each accepted address handshake.
REQ-027 Without SRAM_ARB_RR_EN, data SHALL always win ties (fixed priority), and no RR pointer SHALL exist.

Verification
REQ-028 Single inst read to 0x1C000000, slave addr_ok in the same cycle and data_ok 2 cycles later with rdata 0x12345678 -> inst_addr_ok=1 in cycle 0, inst_data_ok=1 with inst_rdata 0x12345678 in cycle 2, no data_data_ok.
REQ-029 inst_req and data_req both high in IDLE, fixed priority -> data granted first (mem_addr = data_addr), inst granted the next cycle; with SRAM_ARB_RR_EN, the grants alternate over 4 ties: data, inst, data, inst.
REQ-030 inst granted with mem_addr_ok held 0 for 3 cycles while data_req rises in cycle 1 -> mem_addr stays inst_addr until the handshake, then data is granted.
REQ-031 OST_DEPTH=4, five back-to-back requests with no data_ok -> 4 accepted, mem_req=0 for the fifth; a data_ok pop frees one slot, and the fifth is accepted the following cycle.
REQ-032 Order inst, data, inst accepted, then 3 data_ok pulses -> inst_data_ok, data_data_ok, inst_data_ok in that order.
REQ-033 mem_data_ok pulsed with the FIFO empty -> no x_data_ok and err_stray=1 until rst; rst asserted with 2 outstanding -> err_stray=0, FIFO empty, FSM IDLE.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-master (inst/data) to one SRAM-like slave arbiter with in-order response routing.
// Optional round-robin tie-breaking is enabled by defining SRAM_ARB_RR_EN (default: data wins ties).
module sram_arbiter #(
  parameter int OST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_stray
);

  localparam int PTR_W = (OST_DEPTH > 2) ? $clog2(OST_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 lock_side_q, lock_side_d;
  logic [OST_DEPTH-1:0] owner_q, owner_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_stray_q, err_stray_d;
`ifdef SRAM_ARB_RR_EN
  logic                 rr_q, rr_d;
`endif

  logic gnt, win_req, full, empty, push, pop, head;

  // Grant side: 1 = data, 0 = inst
  always_comb begin
    if (state_q == LOCK) begin
      gnt = lock_side_q;
    end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
      gnt = rr_q;
`else
      gnt = 1'b1;
`endif
    end else begin
      gnt = data_req;
    end
  end

  assign win_req = gnt ? data_req : inst_req;
  assign full    = (cnt_q == CNT_W'(OST_DEPTH));
  assign empty   = (cnt_q == {CNT_W{1'b0}});
  assign push    = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & ~empty;
  assign head    = owner_q[rd_ptr_q];

  assign mem_req   = win_req & ~full;
  assign mem_wr    = gnt ? data_wr    : inst_wr;
  assign mem_size  = gnt ? data_size  : inst_size;
  assign mem_wstrb = gnt ? data_wstrb : inst_wstrb;
  assign mem_addr  = gnt ? data_addr  : inst_addr;
  assign mem_wdata = gnt ? data_wdata : inst_wdata;

  assign inst_addr_ok = push & ~gnt;
  assign data_addr_ok = push & gnt;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_stray    = err_stray_q;

  // Next-state for the lock FSM, owner FIFO and stray flag
  always_comb begin
    state_d     = state_q;
    lock_side_d = lock_side_q;
    case (state_q)
      IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_d     = LOCK;
          lock_side_d = gnt;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (mem_addr_ok) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK;
        end
      end
      default: state_d = IDLE;
    endcase

    owner_d = owner_q;
    if (push) begin
      owner_d[wr_ptr_q] = gnt;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    err_stray_d = err_stray_q | (mem_data_ok & empty);
`ifdef SRAM_ARB_RR_EN
    if (push) begin
      rr_d = ~gnt;
    end else begin
      rr_d = rr_q;
    end
`endif
  end

  // State registers; reset leaves the RR pointer favoring data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_side_q <= 1'b0;
      owner_q     <= {OST_DEPTH{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      err_stray_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      rr_q        <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      lock_side_q <= lock_side_d;
      owner_q     <= owner_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_stray_q <= err_stray_d;
`ifdef SRAM_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, corner sequences, randomized run vs queue model.
module tb_sram_arbiter;
  localparam int OST_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd2;
  logic [3:0]  inst_wstrb = 4'hf;
  logic [31:0] inst_addr = 32'h1C00_0000, inst_wdata = 32'hAAAA_5555;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b1;
  logic [1:0]  data_size = 2'd1;
  logic [3:0]  data_wstrb = 4'h3;
  logic [31:0] data_addr = 32'h8000_1000, data_wdata = 32'h0BAD_F00D;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h1234_5678;
  logic        err_stray;

  int ncmp = 0;
  int nerr = 0;

  sram_arbiter #(.OST_DEPTH(OST_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ir, dr, aok, dok;
    logic       gd;
    logic [5:0] exp;  // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_stray}
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic ir, input logic dr, input logic aok, input logic dok);
    @(posedge clk);
    #1;
    inst_req = ir; data_req = dr; mem_addr_ok = aok; mem_data_ok = dok;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [71:0] side_bundle(input logic d);
    if (d) return {1'b0, data_wr, data_size, data_wstrb, data_addr, data_wdata};
    else   return {1'b0, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  endfunction

  function automatic logic [71:0] outs();
    return 72'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_stray});
  endfunction

  initial begin
    logic [3:0] tie_exp;
    bit         q[$];
    bit         locked, lside, rr, err_m, w, wreq, emreq, hs, popm, own;

    // ir dr aok dok gd  {mreq iaok daok idok ddok err}
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b110000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000100};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b101000};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b110000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000010};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000100};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b110000};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b101000};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b110000};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000100};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000010};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000100};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b101001};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000011};

    do_reset();
    #1 check("reset_state", outs(), 72'd0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].ir, tbl[i].dr, tbl[i].aok, tbl[i].dok);
      check($sformatf("vec%0d_flags", i), outs(), 72'(tbl[i].exp));
      check($sformatf("vec%0d_mux", i),
            {1'b0, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, side_bundle(tbl[i].gd));
      if (tbl[i].exp[2] || tbl[i].exp[1])
        check($sformatf("vec%0d_rdata", i), 72'({inst_rdata, data_rdata}), 72'({2{32'h1234_5678}}));
    end

    // Outstanding limit: fifth request is held until a response frees a slot
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("full_accept", 72'({mem_req, inst_addr_ok}), 72'(2'b11));
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("full_block", 72'({mem_req, inst_addr_ok}), 72'(2'b00));
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("full_pop_same_cycle", 72'({mem_req, inst_addr_ok, inst_data_ok}), 72'(3'b001));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("full_reissue", 72'({mem_req, inst_addr_ok, inst_data_ok}), 72'(3'b110));
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("full_drain", 72'({inst_data_ok, data_data_ok}), 72'(2'b10));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("full_no_stray", 72'(err_stray), 72'd0);

    // Four consecutive ties
`ifdef SRAM_ARB_RR_EN
    tie_exp = 4'b1010;
`else
    tie_exp = 4'b1111;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check($sformatf("tie%0d", k), 72'({mem_req, data_addr_ok, inst_addr_ok}),
            72'({1'b1, tie_exp[3-k], ~tie_exp[3-k]}));
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Stray response, then async reset with two outstanding and a locked grant
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("stray_no_ok", 72'({inst_data_ok, data_data_ok, err_stray}), 72'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("stray_sticky", 72'(err_stray), 72'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 inst_req = 1'b0; data_req = 1'b1; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1 check("lock_hold", 72'({mem_req, err_stray}), 72'(2'b01));
    rst = 1'b1;
    #1 check("async_reset", 72'({mem_req, err_stray}), 72'(2'b10));
    check("async_reset_mux", 72'(mem_addr), 72'(data_addr));
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_discard", 72'({inst_data_ok, data_data_ok}), 72'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_then_stray", 72'(err_stray), 72'd1);

    // Randomized traffic against a queue-based model
    do_reset();
    q.delete();
    locked = 1'b0; lside = 1'b0; rr = 1'b1; err_m = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      inst_req    = ($urandom_range(0, 99) < 60);
      data_req    = ($urandom_range(0, 99) < 60);
      mem_addr_ok = ($urandom_range(0, 99) < 55);
      mem_data_ok = ($urandom_range(0, 99) < 40);
      inst_addr   = $urandom; data_addr = $urandom;
      inst_wdata  = $urandom; data_wdata = $urandom;
      inst_wr     = 1'($urandom_range(0, 1)); data_wr = 1'($urandom_range(0, 1));
      mem_rdata   = $urandom;
      @(negedge clk);
      if (locked) w = lside;
      else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
        w = rr;
`else
        w = 1'b1;
`endif
      end else w = data_req;
      wreq  = w ? data_req : inst_req;
      emreq = wreq && (q.size() < OST_DEPTH);
      hs    = emreq && mem_addr_ok;
      popm  = mem_data_ok && (q.size() > 0);
      own   = popm ? q[0] : 1'b0;
      check("rnd_flags", outs(),
            72'({emreq, hs && !w, hs && w, popm && !own, popm && own, err_m}));
      check("rnd_mux", {1'b0, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, side_bundle(w));
      if (popm)
        check("rnd_rdata", 72'(own ? data_rdata : inst_rdata), 72'(mem_rdata));
      if (popm) void'(q.pop_front());
      if (hs) begin
        q.push_back(w);
        rr = ~w;
      end
      if (mem_data_ok && !popm) err_m = 1'b1;
      if (!locked && emreq && !mem_addr_ok) begin
        locked = 1'b1;
        lside  = w;
      end else if (locked && mem_addr_ok) begin
        locked = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
